// File: rtl/lii_stream_demux_wrapper.sv
// LII phy stream demultiplexer: routes each phy beat by its destination code into one of
// NS first-word-fall-through FIFOs feeding an HLS kernel. It drops beats for unmapped
// destinations and drives the kernel clock enable from the registered FIFO occupancy.
module lii_stream_demux_wrapper #(
    parameter int NS       = 2,
    parameter int PW       = 256,
    parameter int SW       = 160,
    parameter int DEPTH    = 4,
    parameter int DST_BASE = 0,
    parameter int CE_SLACK = 1
) (
    input  logic             aclk,
    input  logic             arst,
    input  logic [PW-1:0]    lii_in_tdata,
    input  logic             lii_in_tvalid,
    output logic             lii_in_tready,
    input  logic [7:0]       lii_in_src,
    input  logic [7:0]       lii_in_dst,
    output logic [NS*SW-1:0] out_tdata,
    output logic [NS-1:0]    out_tvalid,
    input  logic [NS-1:0]    out_tready,
    output logic             ce,
    output logic [15:0]      drop_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CE_MAX   = CW'(DEPTH - CE_SLACK);

    logic          mapped;
    logic [IW-1:0] idx;
    logic          sel_full;
    logic          accept;
    logic [NS-1:0] full;
    logic [NS-1:0] below_slack;
    logic [NS-1:0] push;
    logic [NS-1:0] pop;
    logic [15:0]   drop_q, drop_d;

    // Map the destination code onto a stream index; out-of-range codes are unmapped.
    always_comb begin
        int rel;
        rel    = int'(lii_in_dst) - DST_BASE;
        mapped = (rel >= 0) && (rel < NS);
        idx    = IW'(rel);
    end

    // Handshake from registered occupancy only, so a same-cycle pop never frees a full FIFO.
    always_comb begin
        sel_full = 1'b0;
        push     = '0;
        for (int k = 0; k < NS; k++) begin
            if (mapped && (idx == IW'(k))) sel_full = full[k];
        end
        lii_in_tready = !arst && !sel_full;
        accept        = lii_in_tvalid && lii_in_tready;
        for (int k = 0; k < NS; k++) begin
            push[k] = accept && mapped && (idx == IW'(k));
        end
        ce = !arst && (&below_slack);
    end

    // Saturating count of accepted beats that had no stream to go to.
    always_comb begin
        drop_d = drop_q;
        if (accept && !mapped && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    end

    // Drop counter register.
    always_ff @(posedge aclk) begin
        if (arst) drop_q <= '0;
        else      drop_q <= drop_d;
    end

    assign drop_count = drop_q;

    for (genvar k = 0; k < NS; k++) begin : g_fifo
        logic [SW-1:0] mem_q [DEPTH];
        logic [AW-1:0] wr_ptr_q, rd_ptr_q;
        logic [CW-1:0] count_q;

        assign full[k]                = (count_q == FULL_CNT);
        assign below_slack[k]         = (count_q <= CE_MAX);
        assign out_tvalid[k]          = (count_q != '0);
        assign out_tdata[k*SW +: SW]  = mem_q[rd_ptr_q];
        assign pop[k]                 = out_tvalid[k] && out_tready[k];

        // Pointers and occupancy; reset discards whatever the FIFO held.
        always_ff @(posedge aclk) begin
            if (arst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push[k]) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop[k])  rd_ptr_q <= rd_ptr_q + AW'(1);
                unique case ({push[k], pop[k]})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end

        // Payload storage; only the low SW bits of the phy beat are kept.
        always_ff @(posedge aclk) begin
            if (push[k]) mem_q[wr_ptr_q] <= lii_in_tdata[SW-1:0];
        end
    end

    // The source id is deliberately not routed.
    logic unused_src;
    assign unused_src = ^lii_in_src;

    if (PW > SW) begin : g_unused_hi
        logic unused_hi;
        assign unused_hi = ^lii_in_tdata[PW-1:SW];
    end

endmodule

// File: tb/tb_lii_stream_demux_wrapper.sv
// Self-checking bench for lii_stream_demux_wrapper (NS=2, DST_BASE=4, DEPTH=4, CE_SLACK=1).
// A queue-per-stream reference model predicts every output each cycle.
module tb_lii_stream_demux_wrapper;

    localparam int NS = 2;
    localparam int PW = 256;
    localparam int SW = 160;

    logic             aclk = 1'b0;
    logic             arst;
    logic [PW-1:0]    lii_in_tdata;
    logic             lii_in_tvalid;
    logic             lii_in_tready;
    logic [7:0]       lii_in_src;
    logic [7:0]       lii_in_dst;
    logic [NS*SW-1:0] out_tdata;
    logic [NS-1:0]    out_tvalid;
    logic [NS-1:0]    out_tready;
    logic             ce;
    logic [15:0]      drop_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [SW-1:0] mq [NS][$];
    int            m_drop = 0;

    always #5 aclk = ~aclk;

    lii_stream_demux_wrapper #(
        .NS       (NS),
        .PW       (PW),
        .SW       (SW),
        .DEPTH    (4),
        .DST_BASE (4),
        .CE_SLACK (1)
    ) dut (
        .aclk          (aclk),
        .arst          (arst),
        .lii_in_tdata  (lii_in_tdata),
        .lii_in_tvalid (lii_in_tvalid),
        .lii_in_tready (lii_in_tready),
        .lii_in_src    (lii_in_src),
        .lii_in_dst    (lii_in_dst),
        .out_tdata     (out_tdata),
        .out_tvalid    (out_tvalid),
        .out_tready    (out_tready),
        .ce            (ce),
        .drop_count    (drop_count)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [SW-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Check all outputs against the model, then advance the model across one clock edge.
    task automatic cycle();
        bit is_mapped;
        int k;
        bit exp_rdy;
        bit exp_ce;
        #2;
        is_mapped = (lii_in_dst == 8'd4) || (lii_in_dst == 8'd5);
        k         = int'(lii_in_dst) - 4;
        if (arst)           exp_rdy = 1'b0;
        else if (is_mapped) exp_rdy = (mq[k].size() < 4);
        else                exp_rdy = 1'b1;
        exp_ce = !arst && (mq[0].size() <= 3) && (mq[1].size() <= 3);
        check("tready", 256'(lii_in_tready), 256'(exp_rdy));
        check("ce", 256'(ce), 256'(exp_ce));
        check("drop_count", 256'(drop_count), 256'(m_drop));
        for (int s = 0; s < NS; s++) begin
            check("tvalid", 256'(out_tvalid[s]), 256'(mq[s].size() != 0));
            if (mq[s].size() != 0) check("tdata", 256'(out_tdata[s*SW +: SW]), 256'(mq[s][0]));
        end
        if (arst) begin
            for (int s = 0; s < NS; s++) mq[s].delete();
            m_drop = 0;
        end else begin
            for (int s = 0; s < NS; s++) begin
                if (mq[s].size() != 0 && out_tready[s]) void'(mq[s].pop_front());
            end
            if (lii_in_tvalid && exp_rdy) begin
                if (is_mapped)            mq[k].push_back(lii_in_tdata[SW-1:0]);
                else if (m_drop < 65535)  m_drop++;
            end
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic beat(input logic v, input logic [7:0] d, input logic [SW-1:0] data,
                        input logic [1:0] rdy);
        lii_in_tvalid = v;
        lii_in_dst    = d;
        lii_in_src    = 8'($urandom);
        lii_in_tdata  = {$urandom, $urandom, $urandom, data};
        out_tready    = rdy;
        cycle();
    endtask

    initial begin
        arst          = 1'b1;
        lii_in_tvalid = 1'b0;
        lii_in_tdata  = '0;
        lii_in_src    = '0;
        lii_in_dst    = '0;
        out_tready    = '0;
        repeat (2) @(posedge aclk);
        #1;
        // Reset cycles with a valid beat offered: nothing accepted, ce low.
        beat(1'b1, 8'd4, rand_data(), 2'b11);
        beat(1'b1, 8'd5, rand_data(), 2'b11);
        arst = 1'b0;

        // Single beat to stream 1, visible one cycle later, then consumed.
        beat(1'b1, 8'd5, 160'hABC, 2'b11);
        check("single_tvalid", 256'(out_tvalid), 256'(2'b10));
        check("single_tdata", 256'(out_tdata[319:160]), 256'(160'hABC));
        beat(1'b0, 8'd5, '0, 2'b11);
        check("single_drained", 256'(out_tvalid), 256'(2'b00));

        // Fill stream 0 with the kernel stalled; 5th beat refused, stream 1 still open.
        for (int i = 0; i < 4; i++) beat(1'b1, 8'd4, rand_data(), 2'b00);
        check("full_ce", 256'(ce), 256'(1'b0));
        beat(1'b1, 8'd4, rand_data(), 2'b00);
        beat(1'b1, 8'd5, rand_data(), 2'b00);

        // Full FIFO with simultaneous push attempt and pop: push refused, then room again.
        beat(1'b1, 8'd4, rand_data(), 2'b01);
        beat(1'b1, 8'd4, rand_data(), 2'b00);
        for (int i = 0; i < 6; i++) beat(1'b0, 8'd0, '0, 2'b11);

        // Unmapped destination: consumed and counted, never routed.
        for (int i = 0; i < 3; i++) beat(1'b1, 8'h20, rand_data(), 2'b11);
        check("drop_three", 256'(drop_count), 256'(16'd3));
        beat(1'b1, 8'd3, rand_data(), 2'b11);
        beat(1'b1, 8'd6, rand_data(), 2'b11);

        // Drive the drop counter into saturation and past it.
        for (int i = 0; i < 65535; i++) beat(1'b1, 8'h20, '0, 2'b11);
        check("drop_sat", 256'(drop_count), 256'(16'hFFFF));
        for (int i = 0; i < 3; i++) beat(1'b1, 8'h21, '0, 2'b11);
        check("drop_hold", 256'(drop_count), 256'(16'hFFFF));

        // Interleaved and random traffic with random back-pressure.
        for (int i = 0; i < 8; i++) beat(1'b1, (i % 2 == 0) ? 8'd4 : 8'd5, rand_data(),
                                         2'($urandom));
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [7:0] d;
            r = $urandom_range(0, 9);
            d = (r < 4) ? 8'd4 : (r < 8) ? 8'd5 : 8'($urandom);
            beat(($urandom_range(0, 3) != 0), d, rand_data(), 2'($urandom));
        end
        for (int i = 0; i < 10; i++) beat(1'b0, 8'd0, '0, 2'b11);

        // Mid-operation reset with both FIFOs holding data.
        for (int i = 0; i < 4; i++) beat(1'b1, (i % 2 == 0) ? 8'd4 : 8'd5, rand_data(), 2'b00);
        arst = 1'b1;
        beat(1'b1, 8'd4, rand_data(), 2'b00);
        check("rst_tvalid", 256'(out_tvalid), 256'(2'b00));
        check("rst_drop", 256'(drop_count), 256'(16'd0));
        beat(1'b1, 8'd5, rand_data(), 2'b11);
        arst = 1'b0;
        beat(1'b0, 8'd4, '0, 2'b11);
        for (int i = 0; i < 20; i++) beat(1'b1, ($urandom_range(0, 1) != 0) ? 8'd4 : 8'd5,
                                          rand_data(), 2'($urandom));
        for (int i = 0; i < 10; i++) beat(1'b0, 8'd0, '0, 2'b11);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
